// File: rtl/score_display_scan.sv
// Four-digit multiplexed score/lives display with a serial double-dabble BCD converter.
// Optional hit-flash blanking is compiled in with `define SCORE_DISP_FLASH_EN.
module score_display_scan #(
    parameter logic [15:0] SCAN_DIV    = 16'd50000,
    parameter logic [3:0]  FLASH_SLOTS = 4'd8
) (
    input  logic       clk_input,
    input  logic       reset,
    input  logic [6:0] score,
    input  logic [1:0] chance,
    input  logic       key,
    input  logic       touch,
    input  logic       drop,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    logic [1:0]  state;
    logic [6:0]  cap_score;
    // {hundreds[1:0], tens[3:0], ones[3:0], binary[6:0]}
    logic [16:0] shreg;
    logic [16:0] shreg_adj;
    logic [2:0]  shift_cnt;
    logic [3:0]  disp_h, disp_t, disp_o;

    logic [15:0] pre;
    logic        adv;
    logic [1:0]  slot, slot_n;
    logic [6:0]  seg_nx;
    logic [3:0]  an_nx;
    logic        dp_nx;
    logic        flash_on;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    assign busy = (state != ST_IDLE);

    // Hundreds can never reach 5 for a 7-bit input, so only tens and ones need adjusting.
    always_comb begin
        shreg_adj = shreg;
        if (shreg[10:7] >= 4'd5)
            shreg_adj[10:7] = shreg[10:7] + 4'd3;
        if (shreg[14:11] >= 4'd5)
            shreg_adj[14:11] = shreg[14:11] + 4'd3;
    end

    always_ff @(posedge clk_input or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cap_score <= 7'd0;
            shreg     <= 17'd0;
            shift_cnt <= 3'd0;
            disp_h    <= 4'd0;
            disp_t    <= 4'd0;
            disp_o    <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (score != cap_score) begin
                        cap_score <= score;
                        shreg     <= {10'd0, score};
                        shift_cnt <= 3'd0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg     <= {shreg_adj[15:0], 1'b0};
                    shift_cnt <= shift_cnt + 3'd1;
                    if (shift_cnt == 3'd6)
                        state <= ST_LATCH;
                end
                ST_LATCH: begin
                    disp_h <= {2'b00, shreg[16:15]};
                    disp_t <= shreg[14:11];
                    disp_o <= shreg[10:7];
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign adv = (pre == SCAN_DIV - 16'd1);

    always_ff @(posedge clk_input or posedge reset) begin
        if (reset)
            pre <= 16'd0;
        else if (adv)
            pre <= 16'd0;
        else
            pre <= pre + 16'd1;
    end

    // Outputs are prepared for the slot being entered, so they change only on an advance.
    always_comb begin
        slot_n = slot + 2'd1;
        an_nx  = ~(4'b0001 << slot_n);
        dp_nx  = ~((slot_n == 2'd3) && key);
        seg_nx = 7'b1111111;
        case (slot_n)
            2'd0: seg_nx = seg_code(disp_o);
            2'd1: seg_nx = (disp_h == 4'd0 && disp_t == 4'd0) ? 7'b1111111 : seg_code(disp_t);
            2'd2: seg_nx = (disp_h == 4'd0) ? 7'b1111111 : seg_code(disp_h);
            default: seg_nx = seg_code({2'b00, chance});
        endcase
    end

`ifdef SCORE_DISP_FLASH_EN
    logic       hit_q;
    logic       hit_rise;
    logic [3:0] flash_cnt;

    assign hit_rise = (touch | drop) & ~hit_q;
    assign flash_on = (flash_cnt != 4'd0);

    // A fresh hit reloads the counter even mid-flash.
    always_ff @(posedge clk_input or posedge reset) begin
        if (reset) begin
            hit_q     <= 1'b0;
            flash_cnt <= 4'd0;
        end else begin
            hit_q <= touch | drop;
            if (hit_rise)
                flash_cnt <= FLASH_SLOTS;
            else if (adv && flash_on)
                flash_cnt <= flash_cnt - 4'd1;
        end
    end
`else
    logic unused_hit;
    assign unused_hit = touch | drop;
    assign flash_on   = 1'b0;
`endif

    always_ff @(posedge clk_input or posedge reset) begin
        if (reset) begin
            slot <= 2'd0;
            seg  <= 7'b1111111;
            an   <= 4'b1111;
            dp   <= 1'b1;
        end else if (adv) begin
            slot <= slot_n;
            seg  <= seg_nx;
            an   <= flash_on ? 4'b1111 : an_nx;
            dp   <= dp_nx;
        end
    end

endmodule

// File: tb/tb_score_display_scan.sv
// Randomized bench for score_display_scan with a cycle-level behavioural model and directed pins.
module tb_score_display_scan;

    localparam logic [15:0] SD = 16'd4;
    localparam logic [3:0]  FS = 4'd2;

    logic       clk_input = 1'b0;
    logic       reset     = 1'b1;
    logic [6:0] score     = 7'd0;
    logic [1:0] chance    = 2'd0;
    logic       key       = 1'b0;
    logic       touch     = 1'b0;
    logic       drop      = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    score_display_scan #(.SCAN_DIV(SD), .FLASH_SLOTS(FS)) dut (
        .clk_input(clk_input), .reset(reset), .score(score), .chance(chance),
        .key(key), .touch(touch), .drop(drop),
        .seg(seg), .an(an), .dp(dp), .busy(busy)
    );

    always #5 clk_input = ~clk_input;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a conversion is "busy" for 8 cycles after capture, then the value shows.
    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int         m_pre = 0, m_slot = 0, m_cap = 0, m_timer = 0, m_disp = 0, m_flash = 0;
    logic       m_hq  = 1'b0;
    logic [6:0] m_seg = 7'h7f;
    logic [3:0] m_an  = 4'hf;
    logic       m_dp  = 1'b1;

    task automatic model_step();
        if (reset) begin
            m_pre = 0; m_slot = 0; m_cap = 0; m_timer = 0; m_disp = 0; m_flash = 0;
            m_hq = 1'b0; m_seg = 7'h7f; m_an = 4'hf; m_dp = 1'b1;
        end else begin
            if (m_pre == int'(SD) - 1) begin
                m_pre  = 0;
                m_slot = (m_slot + 1) % 4;
                case (m_slot)
                    0: m_seg = segtab[m_disp % 10];
                    1: m_seg = (m_disp < 10)  ? 7'h7f : segtab[(m_disp / 10) % 10];
                    2: m_seg = (m_disp < 100) ? 7'h7f : segtab[m_disp / 100];
                    default: m_seg = segtab[int'(chance)];
                endcase
                m_an = ~(4'b0001 << m_slot);
                m_dp = !(m_slot == 3 && key);
`ifdef SCORE_DISP_FLASH_EN
                if (m_flash > 0) begin
                    m_an = 4'hf;
                    m_flash--;
                end
`endif
            end else begin
                m_pre++;
            end
`ifdef SCORE_DISP_FLASH_EN
            if ((touch | drop) && !m_hq) m_flash = int'(FS);
            m_hq = touch | drop;
`endif
            if (m_timer == 0) begin
                if (int'(score) != m_cap) begin
                    m_cap   = int'(score);
                    m_timer = 8;
                end
            end else begin
                m_timer--;
                if (m_timer == 0) m_disp = m_cap;
            end
        end
    endtask

    initial forever begin
        @(posedge clk_input or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk_input);
        chk("seg", 32'(seg), 32'(m_seg));
        chk("an", 32'(an), 32'(m_an));
        chk("dp", 32'(dp), 32'(m_dp));
        chk("busy", 32'(busy), 32'(m_timer != 0));
    end

    task automatic wait_an(input logic [3:0] a);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_input);
            if (an === a) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_an actual=%b expected=%b (timeout)", an, a);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_input);
        #1;
    endtask

    initial begin
        cyc(3);
        chk("rst_an", 32'(an), 32'hf);
        chk("rst_seg", 32'(seg), 32'h7f);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        cyc(5);
        chk("no_conv_zero", 32'(busy), 32'h0);

        // 0 -> 50
        score = 7'd50;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_input);
            chk("busy_hi", 32'(busy), 32'h1);
        end
        @(negedge clk_input);
        chk("busy_lo", 32'(busy), 32'h0);
        chk("model50", 32'(m_disp), 32'd50);
        wait_an(4'b1110); chk("s50_ones", 32'(seg), 32'h40);
        wait_an(4'b1101); chk("s50_tens", 32'(seg), 32'h12);
        wait_an(4'b1011); chk("s50_hund", 32'(seg), 32'h7f);
        #1;

        // 127, chance 2, key held
        score = 7'd127; chance = 2'd2; key = 1'b1;
        cyc(12);
        chk("model127", 32'(m_disp), 32'd127);
        wait_an(4'b1011); chk("s127_hund", 32'(seg), 32'h79);
        wait_an(4'b0111); chk("s127_chance", 32'(seg), 32'h24); chk("s127_dp", 32'(dp), 32'h0);
        wait_an(4'b1110); chk("s127_ones", 32'(seg), 32'h78); chk("s127_dp1", 32'(dp), 32'h1);
        #1;

        // 7: scan order and leading-zero blanking
        score = 7'd7; key = 1'b0;
        cyc(12);
        wait_an(4'b1110); chk("s7_ones", 32'(seg), 32'h78);
        repeat (4) @(negedge clk_input);
        chk("s7_an1", 32'(an), 32'hd); chk("s7_tens", 32'(seg), 32'h7f);
        repeat (4) @(negedge clk_input);
        chk("s7_an2", 32'(an), 32'hb); chk("s7_hund", 32'(seg), 32'h7f);
        repeat (4) @(negedge clk_input);
        chk("s7_an3", 32'(an), 32'h7);
        #1;

        // 50 then 100 arriving mid-shift
        score = 7'd50;
        cyc(4);
        score = 7'd100;
        repeat (5) @(negedge clk_input);
        chk("restart_gap", 32'(busy), 32'h0);
        chk("model_first", 32'(m_disp), 32'd50);
        @(negedge clk_input);
        chk("restart_busy", 32'(busy), 32'h1);
        repeat (8) @(negedge clk_input);
        chk("restart_done", 32'(busy), 32'h0);
        chk("model100", 32'(m_disp), 32'd100);
        wait_an(4'b1011); chk("s100_hund", 32'(seg), 32'h79);
        wait_an(4'b1110); chk("s100_ones", 32'(seg), 32'h40);
        wait_an(4'b1101); chk("s100_tens", 32'(seg), 32'h40);
        #1;

        // Reset during SHIFT
        score = 7'd99;
        cyc(3);
        reset = 1'b1;
        #1;
        chk("mid_rst_an", 32'(an), 32'hf);
        chk("mid_rst_seg", 32'(seg), 32'h7f);
        chk("mid_rst_dp", 32'(dp), 32'h1);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        score = 7'd0;
        cyc(2);
        reset = 1'b0;
        wait_an(4'b1110); chk("post_rst_ones", 32'(seg), 32'h40);
        chk("post_rst_busy", 32'(busy), 32'h0);
        wait_an(4'b1101); chk("post_rst_tens", 32'(seg), 32'h7f);
        #1;

`ifdef SCORE_DISP_FLASH_EN
        touch = 1'b1;
        cyc(1);
        touch = 1'b0;
        cyc(20);
`endif

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) != 0) score = 7'($urandom_range(0, 127));
            chance = 2'($urandom_range(0, 3));
            key    = 1'($urandom_range(0, 1));
            touch  = ($urandom_range(0, 7) == 0);
            drop   = ($urandom_range(0, 9) == 0);
            cyc($urandom_range(1, 30));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_display_scan.md
SCORE_DISPLAY_SCAN -- requirements
Module: score_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16'd50000, meaning clk_input cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have parameter FLASH_SLOTS, default 4'd8, meaning digit slots blanked per hit flash; legal range 1..15.
REQ-003 SHALL have port clk_input, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port score, input, 7, game score 0..127, unsigned binary.
REQ-006 SHALL have port chance, input, 2, remaining lives 0..3.
REQ-007 SHALL have port key, input, 1, key-held flag.
REQ-008 SHALL have port touch, input, 1, shuriken hit flag.
REQ-009 SHALL have port drop, input, 1, fall flag.
REQ-010 SHALL have port seg, output, 7, active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-011 SHALL have port an, output, 4, active-low digit enables, an[0] rightmost.
REQ-012 SHALL have port dp, output, 1, active-low decimal point.
REQ-013 SHALL have port busy, output, 1, high while the BCD converter is not IDLE.

Function
REQ-014 Converter SHALL be an FSM: IDLE, SHIFT, LATCH.
REQ-015 In IDLE, if score != cap_score, SHALL capture score into cap_score and the shift register, clear the 10-bit BCD accumulator, and enter SHIFT.
REQ-016 SHIFT SHALL run exactly 7 cycles; each cycle adds 3 to every BCD nibble >= 5, then shifts {BCD, binary} left by 1.
REQ-017 LATCH SHALL copy the hundreds, tens and ones nibbles into the display registers in one cycle, then return to IDLE.
REQ-018 Latency from a score change to the updated display registers SHALL be 9 cycles (1 capture + 7 shift + 1 latch).
REQ-019 A score change during SHIFT or LATCH SHALL NOT disturb the conversion in progress; IDLE SHALL detect the mismatch and restart the converter.
REQ-020 The hundreds nibble SHALL be 0 or 1; score 127 SHALL display as 1,2,7.
REQ-021 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; each wrap SHALL advance slot 0->1->2->3->0.
REQ-022 Slot 0 SHALL drive an=1110 with ones; slot 1 an=1101 with tens; slot 2 an=1011 with hundreds; slot 3 an=0111 with chance.
REQ-023 Leading-zero suppression: hundreds SHALL be blank (seg=1111111) when 0; tens SHALL be blank when hundreds and tens are both 0; ones SHALL always show.
REQ-024 dp SHALL be 0 only in slot 3 with key=1; otherwise 1.
REQ-025 Digits 0-9 SHALL use the standard active-low patterns, with 0 shown as 1000000 and 8 as 0000000.
REQ-026 seg, an and dp SHALL be registered and change only on a slot advance.

Reset
REQ-027 While reset is high: an=1111, seg=1111111, dp=1, busy=0, slot=0, prescaler=0, cap_score=0, display registers=0, FSM=IDLE, flash counter=0.
REQ-028 After reset release with score=0, no conversion SHALL start; with score!=0, capture SHALL occur on the first clock edge.
REQ-029 Reset asserted mid-conversion SHALL abort the conversion with no partial latch.

Configuration
REQ-030 Macro SCORE_DISP_FLASH_EN: when defined, a rising edge of (touch|drop), detected by a registered compare, SHALL load FLASH_SLOTS into the flash counter.
REQ-031 With SCORE_DISP_FLASH_EN defined, while the flash counter is nonzero an SHALL be 1111, and the counter SHALL decrement on each slot advance; a new edge during a flash SHALL reload the counter.
REQ-032 Without SCORE_DISP_FLASH_EN, touch and drop SHALL be ignored, and no flash logic SHALL be synthesised.

Verification (SCAN_DIV=4, FLASH_SLOTS=2)
REQ-033 Reset, then score 0->50 -> busy high for 8 cycles; 9 cycles after the change, digits show blank,5,0.
REQ-034 score=127, chance=2, key=1 -> slot 2 seg=1111001 ('1'), slot 3 seg=0100100 ('2') with dp=0, slot 0 seg=1111000 ('7').
REQ-035 score=7 -> an sequence 1110,1101,1011,0111 every 4 cycles; slots 1 and 2 seg=1111111.
REQ-036 score 50->100 at SHIFT cycle 3 -> 50 latches first, then a second conversion follows, and 100 shows within 18 cycles of the first change.
REQ-037 With SCORE_DISP_FLASH_EN defined, a 1-cycle touch pulse -> an=1111 for 2 slot periods (8 cycles), then normal scanning resumes.
REQ-038 Reset asserted during SHIFT -> all outputs take reset values immediately and the display registers stay 0.
